// File: rtl/hpdcache_mem_read_arb.sv
// N-channel read-request arbiter for the HPDcache memory read port.
// Outgoing IDs carry the source channel; responses are routed back by that tag.
module hpdcache_mem_read_arb #(
    parameter int unsigned N_CH    = 4,
    parameter int unsigned ADDR_W  = 56,
    parameter int unsigned ID_W    = 6,
    parameter int unsigned DATA_W  = 512,
    parameter int unsigned MAX_OUT = 4,
    parameter int unsigned RR_EN   = 1,
    localparam int unsigned CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int unsigned CNT_W  = $clog2(MAX_OUT + 1),
    localparam int unsigned MID_W  = CH_W + ID_W
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [N_CH-1:0]        req_valid_i,
    output logic [N_CH-1:0]        req_ready_o,
    input  logic [N_CH*ADDR_W-1:0] req_addr_i,
    input  logic [N_CH*8-1:0]      req_len_i,
    input  logic [N_CH*3-1:0]      req_size_i,
    input  logic [N_CH*ID_W-1:0]   req_id_i,
    output logic                   mem_req_valid_o,
    input  logic                   mem_req_ready_i,
    output logic [ADDR_W-1:0]      mem_req_addr_o,
    output logic [7:0]             mem_req_len_o,
    output logic [2:0]             mem_req_size_o,
    output logic [MID_W-1:0]       mem_req_id_o,
    input  logic                   mem_resp_valid_i,
    output logic                   mem_resp_ready_o,
    input  logic [MID_W-1:0]       mem_resp_id_i,
    input  logic [DATA_W-1:0]      mem_resp_data_i,
    input  logic                   mem_resp_last_i,
    output logic [N_CH-1:0]        resp_valid_o,
    input  logic [N_CH-1:0]        resp_ready_i,
    output logic [ID_W-1:0]        resp_id_o,
    output logic [DATA_W-1:0]      resp_data_o,
    output logic                   resp_last_o,
    output logic                   idle_o,
    output logic                   err_o
);

    logic [N_CH-1:0]   elig;
    logic [N_CH-1:0]   grant;
    logic              any_grant;
    logic [CH_W-1:0]   sel;
    logic [CH_W-1:0]   ptr;
    logic              load;
    logic [CNT_W-1:0]  cnt [N_CH];
    logic [N_CH-1:0]   inc;
    logic [N_CH-1:0]   dec;

    logic [ADDR_W-1:0] sel_addr;
    logic [7:0]        sel_len;
    logic [2:0]        sel_size;
    logic [ID_W-1:0]   sel_id;

    logic [CH_W-1:0]   resp_ch;
    logic              resp_in_range;
    logic              resp_sel_ready;

    // A channel competes only while it is below its outstanding limit
    always_comb begin
        elig = '0;
        for (int unsigned c = 0; c < N_CH; c++) begin
            elig[c] = req_valid_i[c] && (cnt[c] < CNT_W'(MAX_OUT));
        end
    end

    // Pick the eligible channel closest after ptr (RR) or the lowest index
    always_comb begin
        int unsigned best_d;
        int unsigned d;
        best_d    = N_CH;
        d         = 0;
        sel       = '0;
        any_grant = 1'b0;
        grant     = '0;
        for (int unsigned c = 0; c < N_CH; c++) begin
            if (RR_EN != 0) begin
                d = (c + 2 * N_CH - 32'(ptr) - 1) % N_CH;
            end else begin
                d = c;
            end
            if (elig[c] && (d < best_d)) begin
                best_d    = d;
                sel       = CH_W'(c);
                any_grant = 1'b1;
            end
        end
        for (int unsigned c = 0; c < N_CH; c++) begin
            grant[c] = any_grant && (sel == CH_W'(c));
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_len  = '0;
        sel_size = '0;
        sel_id   = '0;
        for (int unsigned c = 0; c < N_CH; c++) begin
            if (grant[c]) begin
                sel_addr = req_addr_i[c*ADDR_W +: ADDR_W];
                sel_len  = req_len_i[c*8 +: 8];
                sel_size = req_size_i[c*3 +: 3];
                sel_id   = req_id_i[c*ID_W +: ID_W];
            end
        end
    end

    assign load        = !mem_req_valid_o || mem_req_ready_i;
    assign req_ready_o = grant & {N_CH{load}};

    // Single output register; holds while the memory side stalls
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_req_valid_o <= 1'b0;
            mem_req_addr_o  <= '0;
            mem_req_len_o   <= '0;
            mem_req_size_o  <= '0;
            mem_req_id_o    <= '0;
            ptr             <= CH_W'(N_CH - 1);
        end else if (load) begin
            mem_req_valid_o <= any_grant;
            if (any_grant) begin
                mem_req_addr_o <= sel_addr;
                mem_req_len_o  <= sel_len;
                mem_req_size_o <= sel_size;
                mem_req_id_o   <= {sel, sel_id};
                ptr            <= sel;
            end
        end
    end

    // Response routing by channel tag; out-of-range tags are sunk
    assign resp_ch       = mem_resp_id_i[ID_W +: CH_W];
    assign resp_in_range = 32'(resp_ch) < N_CH;

    always_comb begin
        resp_valid_o   = '0;
        resp_sel_ready = 1'b0;
        for (int unsigned c = 0; c < N_CH; c++) begin
            if (resp_ch == CH_W'(c)) begin
                resp_valid_o[c] = mem_resp_valid_i;
                resp_sel_ready  = resp_ready_i[c];
            end
        end
    end

    assign mem_resp_ready_o = resp_in_range ? resp_sel_ready : 1'b1;
    assign resp_id_o        = mem_resp_id_i[ID_W-1:0];
    assign resp_data_o      = mem_resp_data_i;
    assign resp_last_o      = mem_resp_last_i;

    always_comb begin
        inc = '0;
        dec = '0;
        for (int unsigned c = 0; c < N_CH; c++) begin
            inc[c] = req_ready_o[c];
            dec[c] = resp_valid_o[c] && mem_resp_ready_o && mem_resp_last_i;
        end
    end

    // Outstanding counters; a simultaneous issue and completion cancel out
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned c = 0; c < N_CH; c++) begin
                cnt[c] <= '0;
            end
        end else begin
            for (int unsigned c = 0; c < N_CH; c++) begin
                if (inc[c] && !dec[c]) begin
                    cnt[c] <= cnt[c] + CNT_W'(1);
                end else if (!inc[c] && dec[c] && (cnt[c] != '0)) begin
                    cnt[c] <= cnt[c] - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_o <= 1'b0;
        end else if (mem_resp_valid_i && !resp_in_range) begin
            err_o <= 1'b1;
        end
    end

    always_comb begin
        idle_o = !mem_req_valid_o;
        for (int unsigned c = 0; c < N_CH; c++) begin
            if (cnt[c] != '0) begin
                idle_o = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hpdcache_mem_read_arb.sv
// Scoreboard bench for hpdcache_mem_read_arb: a 4-channel round-robin instance
// and a 3-channel fixed-priority instance for tag-range and priority checks.
module tb_hpdcache_mem_read_arb;

    logic clk;
    logic rst;

    // 4-channel round-robin instance
    logic [3:0]     req_valid, req_ready;
    logic [4*56-1:0] req_addr;
    logic [31:0]    req_len;
    logic [11:0]    req_size;
    logic [23:0]    req_id;
    logic           mem_req_valid, mem_req_ready;
    logic [55:0]    mem_req_addr;
    logic [7:0]     mem_req_len;
    logic [2:0]     mem_req_size;
    logic [7:0]     mem_req_id;
    logic           mem_resp_valid, mem_resp_ready, mem_resp_last;
    logic [7:0]     mem_resp_id;
    logic [511:0]   mem_resp_data;
    logic [3:0]     resp_valid, resp_ready;
    logic [5:0]     resp_id;
    logic [511:0]   resp_data;
    logic           resp_last, idle, err;

    // 3-channel fixed-priority instance
    logic [2:0]     f_req_valid, f_req_ready;
    logic [3*56-1:0] f_req_addr;
    logic [23:0]    f_req_len;
    logic [8:0]     f_req_size;
    logic [17:0]    f_req_id;
    logic           f_mem_req_valid, f_mem_req_ready;
    logic [55:0]    f_mem_req_addr;
    logic [7:0]     f_mem_req_len;
    logic [2:0]     f_mem_req_size;
    logic [7:0]     f_mem_req_id;
    logic           f_mem_resp_valid, f_mem_resp_ready, f_mem_resp_last;
    logic [7:0]     f_mem_resp_id;
    logic [511:0]   f_mem_resp_data;
    logic [2:0]     f_resp_valid, f_resp_ready;
    logic [5:0]     f_resp_id;
    logic [511:0]   f_resp_data;
    logic           f_resp_last, f_idle, f_err;

    int errors = 0;
    int checks = 0;

    logic [74:0] exp_req  [$];
    logic [42:0] exp_resp [$];
    logic [74:0] mon_req;
    logic [42:0] mon_resp;

    hpdcache_mem_read_arb #(.N_CH(4), .RR_EN(1)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_addr_i(req_addr), .req_len_i(req_len), .req_size_i(req_size), .req_id_i(req_id),
        .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready),
        .mem_req_addr_o(mem_req_addr), .mem_req_len_o(mem_req_len),
        .mem_req_size_o(mem_req_size), .mem_req_id_o(mem_req_id),
        .mem_resp_valid_i(mem_resp_valid), .mem_resp_ready_o(mem_resp_ready),
        .mem_resp_id_i(mem_resp_id), .mem_resp_data_i(mem_resp_data), .mem_resp_last_i(mem_resp_last),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .resp_id_o(resp_id), .resp_data_o(resp_data), .resp_last_o(resp_last),
        .idle_o(idle), .err_o(err)
    );

    hpdcache_mem_read_arb #(.N_CH(3), .RR_EN(0)) u_fp (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(f_req_valid), .req_ready_o(f_req_ready),
        .req_addr_i(f_req_addr), .req_len_i(f_req_len), .req_size_i(f_req_size), .req_id_i(f_req_id),
        .mem_req_valid_o(f_mem_req_valid), .mem_req_ready_i(f_mem_req_ready),
        .mem_req_addr_o(f_mem_req_addr), .mem_req_len_o(f_mem_req_len),
        .mem_req_size_o(f_mem_req_size), .mem_req_id_o(f_mem_req_id),
        .mem_resp_valid_i(f_mem_resp_valid), .mem_resp_ready_o(f_mem_resp_ready),
        .mem_resp_id_i(f_mem_resp_id), .mem_resp_data_i(f_mem_resp_data), .mem_resp_last_i(f_mem_resp_last),
        .resp_valid_o(f_resp_valid), .resp_ready_i(f_resp_ready),
        .resp_id_o(f_resp_id), .resp_data_o(f_resp_data), .resp_last_o(f_resp_last),
        .idle_o(f_idle), .err_o(f_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int c, input logic [55:0] a, input logic [7:0] l,
                          input logic [2:0] s, input logic [5:0] id);
        req_addr[c*56 +: 56] = a;
        req_len[c*8 +: 8]    = l;
        req_size[c*3 +: 3]   = s;
        req_id[c*6 +: 6]     = id;
    endtask

    // Drive one response beat for a cycle; vec is the expected routed valid vector
    task automatic beat(input logic [7:0] tag, input logic [31:0] d, input logic last,
                        input logic [3:0] vec);
        mem_resp_valid = 1'b1;
        mem_resp_id    = tag;
        mem_resp_data  = {480'b0, d};
        mem_resp_last  = last;
        exp_resp.push_back({vec, tag[5:0], d, last});
        step();
        mem_resp_valid = 1'b0;
        mem_resp_last  = 1'b0;
    endtask

    // Monitor: pops the scoreboard on every request or response handshake
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_req_valid && mem_req_ready) begin
                if (exp_req.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req: got id %0h, nothing expected", mem_req_id);
                end else begin
                    mon_req = exp_req.pop_front();
                    chk("mem_req", {mem_req_addr, mem_req_len, mem_req_size, mem_req_id}, mon_req);
                end
            end
            if ((|resp_valid) && mem_resp_ready) begin
                if (exp_resp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got valid %0h, nothing expected", resp_valid);
                end else begin
                    mon_resp = exp_resp.pop_front();
                    chk("resp", {resp_valid, resp_id, resp_data[31:0], resp_last}, mon_resp);
                end
            end
        end
    end

    initial begin
        int order [8];
        order = '{3, 0, 1, 2, 3, 0, 1, 2};
        rst = 1'b1;
        req_valid = '0; req_addr = '0; req_len = '0; req_size = '0; req_id = '0;
        mem_req_ready = 1'b1;
        mem_resp_valid = 1'b0; mem_resp_id = '0; mem_resp_data = '0; mem_resp_last = 1'b0;
        resp_ready = 4'hf;
        f_req_valid = '0; f_req_addr = '0; f_req_len = '0; f_req_size = '0; f_req_id = '0;
        f_mem_req_ready = 1'b1;
        f_mem_resp_valid = 1'b0; f_mem_resp_id = '0; f_mem_resp_data = '0; f_mem_resp_last = 1'b0;
        f_resp_ready = 3'h7;

        // Reset state
        step(); step();
        @(negedge clk);
        chk("rst_mem_req_valid", mem_req_valid, 0);
        chk("rst_mem_req_id", mem_req_id, 0);
        chk("rst_idle", idle, 1);
        chk("rst_err", err, 0);
        step();
        rst = 1'b0;

        // Single channel, 4-beat burst on ch2
        step();
        set_ch(2, 56'h1000, 8'd3, 3'd6, 6'd5);
        req_valid = 4'b0100;
        exp_req.push_back({56'h1000, 8'd3, 3'd6, 8'h85});
        @(negedge clk);
        chk("single_ready", req_ready, 4'b0100);
        step();
        req_valid = '0;
        @(negedge clk);
        chk("single_busy", idle, 0);
        step();
        for (int b = 0; b < 4; b++) begin
            beat(8'h85, 32'hD000_0000 + 32'(b), (b == 3), 4'b0100);
            if (b == 2) chk("burst_busy", idle, 0);
        end
        @(negedge clk);
        chk("single_idle", idle, 1);

        // Round-robin, all four channels valid; pointer sits at ch2
        step();
        for (int c = 0; c < 4; c++) set_ch(c, 56'h2000 + 56'(c * 'h40), 8'd0, 3'd6, 6'(8 + c));
        for (int i = 0; i < 8; i++)
            exp_req.push_back({56'h2000 + 56'(order[i] * 'h40), 8'd0, 3'd6, 2'(order[i]), 6'(8 + order[i])});
        req_valid = 4'hf;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("rr_grant", req_ready, 4'b0001 << order[i]);
            step();
        end
        req_valid = '0;
        step();
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < 4; c++)
                beat({2'(c), 6'(8 + c)}, 32'hA000_0000 + 32'(c), 1'b1, 4'b0001 << c);
        @(negedge clk);
        chk("rr_idle", idle, 1);

        // Backpressure: output held 5 cycles, then ch1 loads on release
        step();
        mem_req_ready = 1'b0;
        set_ch(3, 56'h3000, 8'd1, 3'd5, 6'h11);
        set_ch(1, 56'h3100, 8'd2, 3'd4, 6'h22);
        exp_req.push_back({56'h3000, 8'd1, 3'd5, 8'hD1});
        exp_req.push_back({56'h3100, 8'd2, 3'd4, 8'h62});
        req_valid = 4'b1010;
        @(negedge clk);
        chk("bp_first", req_ready, 4'b1000);
        step();
        req_valid = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_ready_low", req_ready, 0);
            chk("bp_stable", {mem_req_valid, mem_req_addr, mem_req_len, mem_req_size, mem_req_id},
                {1'b1, 56'h3000, 8'd1, 3'd5, 8'hD1});
            step();
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", req_ready, 4'b0010);
        step();
        req_valid = '0;
        beat(8'hD1, 32'hB000_0003, 1'b1, 4'b1000);
        beat(8'h62, 32'hB000_0001, 1'b1, 4'b0010);
        @(negedge clk);
        chk("bp_idle", idle, 1);

        // Throttle ch0 at MAX_OUT, then completion and new request in the same cycle
        step();
        set_ch(0, 56'h4000, 8'd0, 3'd6, 6'h03);
        req_valid = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            exp_req.push_back({56'h4000, 8'd0, 3'd6, 8'h03});
            @(negedge clk);
            chk("thr_fill", req_ready, 4'b0001);
            step();
        end
        mem_resp_valid = 1'b1;
        mem_resp_id    = 8'h03;
        mem_resp_data  = {480'b0, 32'hC000_0000};
        mem_resp_last  = 1'b1;
        exp_resp.push_back({4'b0001, 6'h03, 32'hC000_0000, 1'b1});
        @(negedge clk);
        chk("thr_masked", req_ready, 0);
        step();
        mem_resp_valid = 1'b0;
        mem_resp_last  = 1'b0;
        exp_req.push_back({56'h4000, 8'd0, 3'd6, 8'h03});
        @(negedge clk);
        chk("thr_reaccept", req_ready, 4'b0001);
        step();
        @(negedge clk);
        chk("thr_full_again", req_ready, 0);
        step();
        req_valid = '0;
        for (int i = 0; i < 4; i++) beat(8'h03, 32'hC000_0010 + 32'(i), 1'b1, 4'b0001);
        @(negedge clk);
        chk("thr_idle", idle, 1);

        // Fixed priority on the 3-channel instance
        step();
        f_req_valid = 3'b111;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("fp_ch0", f_req_ready, 3'b001);
            step();
        end
        @(negedge clk);
        chk("fp_ch1", f_req_ready, 3'b010);
        step();
        f_req_valid = '0;

        // Out-of-range tag 3 on the 3-channel instance
        f_mem_resp_valid = 1'b1;
        f_mem_resp_id    = 8'hC0;
        f_mem_resp_last  = 1'b1;
        f_resp_ready     = 3'b000;
        @(negedge clk);
        chk("oor_ready", f_mem_resp_ready, 1);
        chk("oor_no_valid", f_resp_valid, 0);
        chk("oor_err_pre", f_err, 0);
        step();
        f_mem_resp_valid = 1'b0;
        f_mem_resp_last  = 1'b0;
        @(negedge clk);
        chk("oor_err", f_err, 1);
        step(); step();
        @(negedge clk);
        chk("oor_err_sticky", f_err, 1);
        chk("oor_no_count_change", f_idle, 0);

        // Asynchronous reset with a request stuck in the output stage
        step();
        mem_req_ready = 1'b0;
        set_ch(1, 56'h5000, 8'd0, 3'd6, 6'h01);
        req_valid = 4'b0010;
        step();
        req_valid = '0;
        @(negedge clk);
        chk("ar_pending", {mem_req_valid, idle}, 2'b10);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_valid", mem_req_valid, 0);
        chk("ar_idle", idle, 1);
        chk("ar_f_err", f_err, 0);
        chk("ar_f_idle", f_idle, 1);
        step();
        rst = 1'b0;
        mem_req_ready = 1'b1;
        req_valid = 4'hf;
        @(negedge clk);
        chk("ar_rr_ptr", req_ready, 4'b0001);
        req_valid = '0;
        step(); step();

        chk("req_queue_empty", exp_req.size(), 0);
        chk("resp_queue_empty", exp_resp.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hpdcache_mem_read_arb.md
Name: hpdcache_mem_read_arb

Overview:
- Parametrised N-channel arbiter for the HPDcache memory read interface. Merges N requester read-request channels into one memory read port.
- Tags each outgoing ID with the source channel index. Routes multi-beat read responses back by that tag.
- Enforces a per-channel outstanding-transaction limit.
- Sits between several cache/prefetch read masters and the single memory read request/response port of the cache subsystem.

Parameters:
- N_CH, 4, number of requester channels (>=1)
- ADDR_W, 56, memory address width
- ID_W, 6, per-channel transaction ID width
- DATA_W, 512, response data width
- MAX_OUT, 4, max outstanding transactions per channel (>=1)
- RR_EN, 1, 1 = round-robin arbitration, 0 = fixed priority (lowest index wins)
- Derived: CH_W = max(1, clog2(N_CH)); CNT_W = clog2(MAX_OUT+1)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset
- req_valid_i  in  N_CH  per-channel request valid
- req_ready_o  out  N_CH  per-channel request ready
- req_addr_i  in  N_CH*ADDR_W  request address
- req_len_i  in  N_CH*8  beats minus one
- req_size_i  in  N_CH*3  log2 bytes per beat
- req_id_i  in  N_CH*ID_W  channel-local ID
- mem_req_valid_o  out  1  memory request valid
- mem_req_ready_i  in  1  memory request ready
- mem_req_addr_o  out  ADDR_W  address
- mem_req_len_o  out  8  length
- mem_req_size_o  out  3  size
- mem_req_id_o  out  CH_W+ID_W  {channel, id}
- mem_resp_valid_i  in  1  response beat valid
- mem_resp_ready_o  out  1  response beat ready
- mem_resp_id_i  in  CH_W+ID_W  response ID
- mem_resp_data_i  in  DATA_W  response data
- mem_resp_last_i  in  1  last beat
- resp_valid_o  out  N_CH  per-channel response valid
- resp_ready_i  in  N_CH  per-channel response ready
- resp_id_o  out  ID_W  stripped ID, broadcast
- resp_data_o  out  DATA_W  data, broadcast
- resp_last_o  out  1  last, broadcast
- idle_o  out  1  no outstanding transactions and output stage empty
- err_o  out  1  sticky: response with out-of-range channel tag

Behaviour:
- Reset: rst_i is asynchronous and active-high. Clock is clk_i, single domain. Reset values:
  - mem_req_valid_o=0, out-stage fields 0
  - RR pointer = N_CH-1, so channel 0 is favoured first
  - all outstanding counters 0
  - err_o=0, idle_o=1
- Reset asserted mid-transfer: everything above is cleared immediately, and in-flight responses are forgotten.
- Eligibility: channel c is eligible iff req_valid_i[c] && cnt[c] < MAX_OUT.
- Arbitration (combinational, per cycle):
  - RR_EN=1: first eligible channel searching from ptr+1 upward, wrapping modulo N_CH.
  - RR_EN=0: lowest eligible index.
- Output stage: one register. load = !mem_req_valid_o || mem_req_ready_i.
  - req_ready_o[c] = grant[c] && load. At most one bit is set.
  - On handshake: latch fields, set mem_req_id_o = {c[CH_W-1:0], req_id_i[c]}, and set ptr <= c.
  - If load is asserted and no channel is eligible, mem_req_valid_o <= 0.
  - Latency is 1 cycle input→output. Full throughput of 1 req/cycle under constant mem_req_ready_i.
  - Outputs stay stable while valid && !ready.
- Outstanding counters:
  - cnt[c] increments on an input handshake of channel c.
  - cnt[c] decrements on a response handshake with mem_resp_last_i routed to c.
  - Simultaneous increment and decrement leaves cnt[c] unchanged.
  - A channel at MAX_OUT is masked: req_ready_o stays 0 even with valid high.
- Response routing (combinational, no storage):
  - ch = mem_resp_id_i[ID_W +: CH_W]
  - resp_valid_o[ch] = mem_resp_valid_i; all other bits 0
  - mem_resp_ready_o = resp_ready_i[ch]
  - resp_id_o = low ID_W bits of mem_resp_id_i
  - Multi-beat bursts pass beat by beat. Backpressure from resp_ready_i stalls the memory side.
- Out-of-range tag (ch >= N_CH, only possible for non-power-of-2 N_CH):
  - mem_resp_ready_o=1, the beat is dropped, no resp_valid_o is asserted, no counter changes.
  - err_o <= 1 and stays set until reset.
- idle_o = !mem_req_valid_o && all cnt == 0.
- N_CH=1: CH_W=1, and the tag bit is always 0.

Test Plan:
- Single channel: ch2 req addr 0x1000, id 5, len 3, with mem_req_ready_i=1 → mem_req_valid_o asserted next cycle, mem_req_id_o={2'd2,6'd5}. Return 4 beats with id {2,5} → resp_valid_o=4'b0100 for 4 beats, resp_last_o on beat 4, cnt[2] goes 0→1→0, idle_o returns to 1.
- Round-robin: all 4 channels valid continuously, mem_req_ready_i=1 → grant order 0,1,2,3,0,… one per cycle. With RR_EN=0, channel 0 wins every cycle until MAX_OUT=4 is reached, then channel 1 is granted.
- Backpressure: mem_req_ready_i=0 for 5 cycles with output valid → mem_req_* stable, all req_ready_o=0. Release → new grant loaded the same cycle.
- Throttle and simultaneous events: ch0 at cnt=4 → req_ready_o[0]=0. A last beat for ch0 arrives in the same cycle as a new ch0 request is allowed → counter ends at 4 (the request is accepted the following cycle).
- N_CH=3: response tagged ch=3 → mem_resp_ready_o=1, resp_valid_o=0, err_o=1 sticky. Assert rst_i → err_o=0, idle_o=1 asynchronously.
